ps2_keyboard_rx: RTL and testbench

Memory-mapped PS/2 keyboard receiver: the input-direction counterpart of the character display path. It deserialises 11-bit PS/2 device-to-host frames, buffers scan-code bytes in a FIFO, and exposes them to the CPU through a data/status register pair. It sits beside the memory-management block on the CPU bus (`address`, `wdata`, `wboolean`, `rdata`) in the CPU clock domain.

---
 rtl/ps2_keyboard_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames into a scan-code FIFO read through DATA/STATUS registers.
// Optional macro KBD_BREAK_FILTER_EN drops F0 break prefixes and the key code that follows each one.
module ps2_keyboard_rx #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
   parameter int          FIFO_DEPTH     = 16,
   parameter int          TIMEOUT_CYCLES = 25000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        wboolean,
   output logic [31:0] rdata,
   output logic        kbd_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PARITY = 2'd2, ST_STOP = 2'd3} state_t;

   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic          ps2c_s1_q, ps2c_s2_q, ps2c_prev_q, ps2d_s1_q, ps2d_s2_q;
   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ov_q, pe_q, fe_q, kbd_ready_q;
   logic          fall_s, bit_s, good_s, pe_set_s, fe_set_s, tmo_hit_s;
   logic          push_s, pop_s, wr_s, full_s, empty_s, ov_set_s, st_wr_s;
   logic [4:0]    cnt5_s;
   logic          unused_s;

   assign fall_s   = ps2c_prev_q & ~ps2c_s2_q;
   assign bit_s    = ps2d_s2_q;
   assign unused_s = ^{wdata[31:5], wdata[1:0]};

   // Two-flop synchronisers plus delayed clock copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         ps2c_s1_q   <= 1'b1;
         ps2c_s2_q   <= 1'b1;
         ps2c_prev_q <= 1'b1;
         ps2d_s1_q   <= 1'b1;
         ps2d_s2_q   <= 1'b1;
      end else begin
         ps2c_s1_q   <= ps2_clk;
         ps2c_s2_q   <= ps2c_s1_q;
         ps2c_prev_q <= ps2c_s2_q;
         ps2d_s1_q   <= ps2_data;
         ps2d_s2_q   <= ps2d_s1_q;
      end
   end

   // Frame state and receive datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         shift_q  <= 8'h00;
         bitcnt_q <= 3'd0;
         par_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
      end
   end

   // Frame FSM next-state; advances only on synchronised PS/2 falling edges
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      par_d     = par_q;
      tmo_d     = tmo_q;
      good_s    = 1'b0;
      pe_set_s  = 1'b0;
      fe_set_s  = 1'b0;
      tmo_hit_s = 1'b0;
      if (fall_s) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!bit_s) begin
                  state_d  = ST_DATA;
                  bitcnt_d = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_d  = {bit_s, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = ST_PARITY;
               else                  state_d = ST_DATA;
            end
            ST_PARITY: begin
               par_d   = bit_s;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               good_s   = bit_s & odd_parity_ok(shift_q, par_q);
               pe_set_s = ~odd_parity_ok(shift_q, par_q);
               fe_set_s = ~bit_s;
               state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TMO_C) begin
            state_d   = ST_IDLE;
            tmo_d     = '0;
            tmo_hit_s = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

`ifdef KBD_BREAK_FILTER_EN
   logic break_q, break_d;

   // Break filter: F0 arms, the following good byte is swallowed
   always_comb begin
      break_d = break_q;
      push_s  = 1'b0;
      if (good_s) begin
         if (shift_q == 8'hF0) begin
            break_d = 1'b1;
         end else if (break_q) begin
            break_d = 1'b0;
         end else begin
            push_s = 1'b1;
         end
      end else if (tmo_hit_s) begin
         break_d = 1'b0;
      end else begin
         break_d = break_q;
      end
   end

   // Break-pending flag register
   always_ff @(posedge clk) begin
      if (!reset) break_q <= 1'b0;
      else        break_q <= break_d;
   end
`else
   assign push_s = good_s;
`endif

   assign empty_s  = (count_q == '0);
   assign full_s   = (count_q == DEPTH_C);
   assign pop_s    = wboolean && (address == BASE_ADDR) && !empty_s;
   assign st_wr_s  = wboolean && (address == (BASE_ADDR + 32'd4));
   // A push into a full FIFO still lands when the head is popped in the same cycle
   assign wr_s     = push_s && (!full_s || pop_s);
   assign ov_set_s = push_s && full_s && !pop_s;
   assign count_d  = count_q + CW'(wr_s) - CW'(pop_s);
   assign cnt5_s   = 5'(count_q);

   // Scan-code storage; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (wr_s) fifo_q[wr_ptr_q] <= shift_q;
   end

   // FIFO pointers, count, sticky flags and ready output
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ov_q        <= 1'b0;
         pe_q        <= 1'b0;
         fe_q        <= 1'b0;
         kbd_ready_q <= 1'b0;
      end else begin
         if (wr_s)  wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q     <= count_d;
         ov_q        <= ov_set_s | (ov_q & ~(st_wr_s & wdata[2]));
         pe_q        <= pe_set_s | (pe_q & ~(st_wr_s & wdata[3]));
         fe_q        <= fe_set_s | (fe_q & ~(st_wr_s & wdata[4]));
         // Lags a push by one cycle but drops together with the emptying pop
         kbd_ready_q <= (count_d != '0) && (count_q != '0);
      end
   end

   assign kbd_ready = kbd_ready_q;

   // Register read mux
   always_comb begin
      rdata = 32'h0000_0000;
      if (address == BASE_ADDR) begin
         if (!empty_s) rdata = {23'd0, 1'b1, fifo_q[rd_ptr_q]};
         else          rdata = 32'h0000_0000;
      end else if (address == (BASE_ADDR + 32'd4)) begin
         rdata = {19'd0, cnt5_s, 3'd0, fe_q, pe_q, ov_q, full_s, !empty_s};
      end else begin
         rdata = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx: framing, errors, FIFO limits, timeout, push/pop collision.
module tb_ps2_keyboard_rx;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam logic [31:0] STAT = 32'h0000_0404;

   logic        clk = 1'b0;
   logic        reset, ps2_clk, ps2_data, wboolean, kbd_ready;
   logic [31:0] address, wdata, rdata, v;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   ps2_keyboard_rx #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(300)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .address(address), .wdata(wdata), .wboolean(wboolean),
      .rdata(rdata), .kbd_ready(kbd_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk); ps2_data = b;
      repeat (5) @(negedge clk); ps2_clk = 1'b0;
      repeat (10) @(negedge clk); ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int nbits);
      logic [10:0] f;
      f = {stop, (~^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] r);
      @(negedge clk); address = a;
      #1 r = rdata;
      address = 32'h0;
   endtask

   task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); address = a; wdata = d; wboolean = 1'b1;
      @(negedge clk); wboolean = 1'b0; address = 32'h0; wdata = 32'h0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      address = 32'h0; wdata = 32'h0; wboolean = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("rst_ready", {31'd0, kbd_ready}, 32'd0);
      read_reg(BASE, v); check_eq("rst_data", v, 32'h0);
      read_reg(STAT, v); check_eq("rst_status", v, 32'h0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // single 1C frame with timed stop bit
      send_frame(8'h1C, 1'b0, 1'b1, 10);
      @(negedge clk); ps2_data = 1'b1;
      repeat (5) @(negedge clk); ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_eq("ready_lat3", {31'd0, kbd_ready}, 32'd0);
      @(posedge clk);
      #1 check_eq("ready_lat4", {31'd0, kbd_ready}, 32'd1);
      repeat (6) @(negedge clk); ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
      read_reg(BASE, v); check_eq("single_data", v, 32'h0000_011C);
      read_reg(STAT, v); check_eq("single_status", v, 32'h0000_0101);
      write_reg(BASE, 32'hFFFF_FFFF);
      check_eq("pop_ready", {31'd0, kbd_ready}, 32'd0);
      read_reg(BASE, v); check_eq("pop_data", v, 32'h0);

      // bad parity, then bad stop
      send_frame(8'h1C, 1'b1, 1'b1, 11);
      check_eq("perr_ready", {31'd0, kbd_ready}, 32'd0);
      read_reg(STAT, v); check_eq("perr_status", v, 32'h0000_0008);
      write_reg(STAT, 32'h0000_0008);
      read_reg(STAT, v); check_eq("perr_clear", v, 32'h0);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      read_reg(STAT, v); check_eq("ferr_status", v, 32'h0000_0010);
      write_reg(STAT, 32'h0000_0010);
      read_reg(STAT, v); check_eq("ferr_clear", v, 32'h0);

      // 17 frames into a 16-deep FIFO
      for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b1, 11);
      read_reg(STAT, v); check_eq("full_status", v, 32'h0000_1007);
      for (int i = 0; i < 16; i++) begin
         read_reg(BASE, v); check_eq($sformatf("order%0d", i), v, 32'h100 | 32'(8'h40 + 8'(i)));
         write_reg(BASE, 32'h0);
      end
      write_reg(BASE, 32'h0);
      read_reg(BASE, v); check_eq("empty_data", v, 32'h0);
      read_reg(STAT, v); check_eq("empty_status", v, 32'h0000_0004);
      write_reg(STAT, 32'h0000_0004);
      read_reg(STAT, v); check_eq("ovf_clear", v, 32'h0);

      // truncated frame recovered by timeout
      send_frame(8'h32, 1'b0, 1'b1, 5);
      repeat (400) @(negedge clk);
      send_frame(8'h32, 1'b0, 1'b1, 11);
      read_reg(STAT, v); check_eq("tmo_status", v, 32'h0000_0101);
      read_reg(BASE, v); check_eq("tmo_data", v, 32'h0000_0132);
      write_reg(BASE, 32'h0);

      // simultaneous push and pop at count 3
      send_frame(8'hA1, 1'b0, 1'b1, 11);
      send_frame(8'hA2, 1'b0, 1'b1, 11);
      send_frame(8'hA3, 1'b0, 1'b1, 11);
      send_frame(8'hA4, 1'b0, 1'b1, 10);
      @(negedge clk); ps2_data = 1'b1;
      repeat (5) @(negedge clk); ps2_clk = 1'b0;
      @(negedge clk);
      @(negedge clk); address = BASE; wboolean = 1'b1;
      @(negedge clk); wboolean = 1'b0; address = 32'h0;
      read_reg(STAT, v); check_eq("pp_status", v, 32'h0000_0301);
      check_eq("pp_ready", {31'd0, kbd_ready}, 32'd1);
      repeat (4) @(negedge clk); ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         read_reg(BASE, v); check_eq($sformatf("pp_order%0d", i), v, 32'h100 | 32'(8'hA2 + 8'(i)));
         write_reg(BASE, 32'h0);
      end
      check_eq("pp_drained", {31'd0, kbd_ready}, 32'd0);

      // break-code sequence
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      send_frame(8'hF0, 1'b0, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      send_frame(8'h32, 1'b0, 1'b1, 11);
`ifdef KBD_BREAK_FILTER_EN
      exp_q = '{8'h1C, 8'h32};
`else
      exp_q = '{8'h1C, 8'hF0, 8'h1C, 8'h32};
`endif
      read_reg(STAT, v); check_eq("brk_count", {27'd0, v[12:8]}, 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         read_reg(BASE, v); check_eq($sformatf("brk%0d", i), v, 32'h100 | 32'(exp_q[i]));
         write_reg(BASE, 32'h0);
      end

      // reset clears a non-empty FIFO
      send_frame(8'h55, 1'b0, 1'b1, 11);
      check_eq("pre_rst_ready", {31'd0, kbd_ready}, 32'd1);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      check_eq("post_rst_ready", {31'd0, kbd_ready}, 32'd0);
      read_reg(STAT, v); check_eq("post_rst_status", v, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
